// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int SM_W   = 3;

    // Sequencer states: SYNC waits for the memory to go quiet, IDLE arbitrates,
    // ISSUE is the single strobe cycle, WAIT follows mem_clk_stall.
    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    localparam logic [DATA_W-1:0] ABORT_DATA_DEFAULT = 32'hDEADBEEF;

    // Width/sign codes as used by the rv32i core: {unsigned, size[1:0]}.
    localparam logic [SM_W-1:0] SM_BYTE   = 3'b000;
    localparam logic [SM_W-1:0] SM_HALF   = 3'b001;
    localparam logic [SM_W-1:0] SM_WORD   = 3'b010;
    localparam logic [SM_W-1:0] SM_BYTE_U = 3'b100;
    localparam logic [SM_W-1:0] SM_HALF_U = 3'b101;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way arbiter: combinational pick plus registered last-grant pointer.
module dmem_arbiter_rr_arb2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic       pick_o,
    output logic       any_o
);

    // last_q holds the index granted most recently; reset value 1 gives
    // requester 0 priority on the first contention.
    logic last_q;
    logic last_d;

    // Choose the winner and compute the pointer update on grant.
    always_comb begin
        any_o  = |req_i;
        pick_o = 1'b0;
        if (FIXED_PRIO) begin
            pick_o = ~req_i[0];
        end else if (&req_i) begin
            pick_o = ~last_q;
        end else begin
            pick_o = req_i[1];
        end
        last_d = take_i ? pick_o : last_q;
    end

    // Last-grant pointer register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer in front of the data memory's single load/store port.
// Turns level req/done handshakes into one-cycle memread/memwrite strobes and
// tracks mem_clk_stall, with a watchdog for a hung memory.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter bit                FIXED_PRIO     = 1'b0,
    parameter int unsigned       TIMEOUT_CYCLES = 16,
    parameter logic [DATA_W-1:0] ABORT_DATA     = ABORT_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r1_req,
    input  logic              r0_we,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic [SM_W-1:0]   r0_sign_mask,
    input  logic [SM_W-1:0]   r1_sign_mask,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_done,
    output logic              r1_done,
    output logic [DATA_W-1:0] r0_rdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [SM_W-1:0]   mem_sign_mask,
    output logic              mem_memread,
    output logic              mem_memwrite,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_clk_stall,
    output logic              busy,
    output logic              err
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    state_e                  state_q, state_d;
    logic [31:0]             cnt_q, cnt_d;
    logic                    win_q, win_d;
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [SM_W-1:0]         sm_q, sm_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic [1:0]              gnt_q, gnt_d;
    logic [1:0]              done_q, done_d;
    logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic pick;
    logic any_req;
    logic take;

    dmem_arbiter_rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk_i   (clk),
        .reset_i (reset),
        .req_i   ({r1_req, r0_req}),
        .take_i  (take),
        .pick_o  (pick),
        .any_o   (any_req)
    );

    // Next-state logic; strobes, grants and dones default to 0 so they can
    // only ever be high for the single cycle they are set.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sm_d    = sm_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        rdata_d = rdata_q;
        err_d   = err_q;
        take    = 1'b0;

        case (state_q)
            ST_SYNC: begin
                // The memory has no reset; wait until it is not mid-access.
                if (!mem_clk_stall) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (any_req) begin
                    take        = 1'b1;
                    win_d       = pick;
                    we_d        = pick ? r1_we        : r0_we;
                    addr_d      = pick ? r1_addr      : r0_addr;
                    wdata_d     = pick ? r1_wdata     : r0_wdata;
                    sm_d        = pick ? r1_sign_mask : r0_sign_mask;
                    rd_d        = pick ? ~r1_we       : ~r0_we;
                    wr_d        = pick ? r1_we        : r0_we;
                    gnt_d[pick] = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Gives the memory one edge to see the strobe and raise stall.
                cnt_d   = 32'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!mem_clk_stall) begin
                    done_d[win_q] = 1'b1;
                    if (!we_q) begin
                        rdata_d[win_q] = mem_read_data;
                    end
                    state_d = ST_IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
                    err_d         = 1'b1;
                    done_d[win_q] = 1'b1;
                    if (!we_q) begin
                        rdata_d[win_q] = ABORT_DATA;
                    end
                    state_d = ST_SYNC;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sm_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sm_q    <= sm_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign r0_gnt         = gnt_q[0];
    assign r1_gnt         = gnt_q[1];
    assign r0_done        = done_q[0];
    assign r1_done        = done_q[1];
    assign r0_rdata       = rdata_q[0];
    assign r1_rdata       = rdata_q[1];
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_sign_mask  = sm_q;
    assign mem_memread    = rd_q;
    assign mem_memwrite   = wr_q;
    assign busy           = (state_q != ST_IDLE);
    assign err            = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: instance 0 is round-robin, instance 1 fixed priority;
// both see the same requester stimulus and each has its own memory model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        r0_req, r1_req, r0_we, r1_we;
    logic [13:0] r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic [2:0]  r0_sm, r1_sm;
    logic [31:0] mem_data;
    logic        hang;

    logic [1:0]  gnt   [2];
    logic [1:0]  done  [2];
    logic [31:0] rd0   [2];
    logic [31:0] rd1   [2];
    logic [13:0] maddr [2];
    logic [31:0] mwd   [2];
    logic [2:0]  msm   [2];
    logic        mrd   [2];
    logic        mwr   [2];
    logic        busy  [2];
    logic        err   [2];
    logic [1:0]  stall = 2'b00;
    int          rdcnt [2] = '{0, 0};

    int total = 0;
    int bad   = 0;
    int base;
    int k;

    dmem_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT_CYCLES(16)) u_rr (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
        .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_sign_mask(r0_sm), .r1_sign_mask(r1_sm),
        .r0_gnt(gnt[0][0]), .r1_gnt(gnt[0][1]), .r0_done(done[0][0]), .r1_done(done[0][1]),
        .r0_rdata(rd0[0]), .r1_rdata(rd1[0]),
        .mem_addr(maddr[0]), .mem_write_data(mwd[0]), .mem_sign_mask(msm[0]),
        .mem_memread(mrd[0]), .mem_memwrite(mwr[0]),
        .mem_read_data(mem_data), .mem_clk_stall(stall[0]),
        .busy(busy[0]), .err(err[0])
    );

    dmem_arbiter #(.FIXED_PRIO(1'b1), .TIMEOUT_CYCLES(16)) u_fp (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
        .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_sign_mask(r0_sm), .r1_sign_mask(r1_sm),
        .r0_gnt(gnt[1][0]), .r1_gnt(gnt[1][1]), .r0_done(done[1][0]), .r1_done(done[1][1]),
        .r0_rdata(rd0[1]), .r1_rdata(rd1[1]),
        .mem_addr(maddr[1]), .mem_write_data(mwd[1]), .mem_sign_mask(msm[1]),
        .mem_memread(mrd[1]), .mem_memwrite(mwr[1]),
        .mem_read_data(mem_data), .mem_clk_stall(stall[1]),
        .busy(busy[1]), .err(err[1])
    );

    // Memory model: a strobe raises stall for one cycle (3-cycle access);
    // hang keeps stall high to emulate a stuck or mid-operation memory.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mrd[i]) rdcnt[i] <= rdcnt[i] + 1;
            if (hang)                 stall[i] <= 1'b1;
            else if (stall[i])        stall[i] <= 1'b0;
            else if (mrd[i] | mwr[i]) stall[i] <= 1'b1;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; hang = 1'b0; mem_data = 32'h0;
        r0_req = 0; r1_req = 0; r0_we = 0; r1_we = 0;
        r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0; r0_sm = '0; r1_sm = '0;
        repeat (3) tick();

        // Reset state
        check("rst_gnt_done", {28'd0, gnt[0], done[0]}, 32'h0);
        check("rst_strobes",  {29'd0, mrd[0], mwr[0], err[0]}, 32'h0);
        check("rst_rdata",    rd0[0] | rd1[0], 32'h0);
        check("rst_mem_flds", {4'd0, maddr[0], 11'd0, msm[0]} | mwd[0], 32'h0);
        check("rst_busy",     busy[0], 1);
        reset = 1'b0;
        tick();
        check("sync_to_idle", busy[0], 0);

        // Contention: both held for 4 transactions
        r0_req = 1; r1_req = 1; mem_data = 32'h11111111;
        for (int t = 0; t < 16; t++) begin
            tick();
            if (t % 4 == 0) begin
                check($sformatf("rr_gnt%0d", t / 4), gnt[0], ((t / 4) % 2 == 0) ? 2'b01 : 2'b10);
                check($sformatf("fp_gnt%0d", t / 4), gnt[1], 2'b01);
            end
            if (t == 15) begin
                check("cont_last_done", done[0], 2'b10);
                r0_req = 0; r1_req = 0;
            end
        end
        tick();
        check("cont_quiet", {gnt[0], done[0], 3'd0, busy[0]}, 0);

        // Single load
        r0_we = 0; r0_addr = 14'h0010; r0_sm = 3'b010; mem_data = 32'h12345678;
        r0_req = 1; base = rdcnt[0];
        tick();
        check("ld_gnt",   gnt[0], 2'b01);
        check("ld_rdwr",  {mrd[0], mwr[0]}, 2'b10);
        check("ld_addr",  maddr[0], 14'h0010);
        r0_addr = 14'h0044;
        tick();
        check("ld_strobe_off", {gnt[0], mrd[0], mwr[0]}, 0);
        check("ld_addr_held",  maddr[0], 14'h0010);
        tick();
        check("ld_not_yet", done[0], 0);
        tick();
        check("ld_done",  done[0], 2'b01);
        check("ld_rdata", rd0[0], 32'h12345678);
        r0_req = 0;
        check("ld_one_read", rdcnt[0] - base, 1);
        tick();
        check("ld_done_pulse", {done[0], 1'b0, busy[0]}, 0);

        // LED store by r1
        mem_data = 32'hCAFEF00D;
        r1_we = 1; r1_addr = 14'h2000; r1_wdata = 32'h3; r1_sm = 3'b010; r1_req = 1;
        tick();
        check("st_gnt",   gnt[0], 2'b10);
        check("st_rdwr",  {mrd[0], mwr[0]}, 2'b01);
        check("st_addr",  maddr[0], 14'h2000);
        check("st_wdata", mwd[0], 32'h3);
        check("st_sm",    msm[0], 3'b010);
        r1_wdata = 32'hFFFFFFFF;
        tick();
        check("st_wr_off",    mwr[0], 0);
        check("st_wdata_hold", mwd[0], 32'h3);
        tick();
        tick();
        check("st_done",     done[0], 2'b10);
        check("st_rdata_r1", rd1[0], 32'h11111111);
        check("st_rdata_r0", rd0[0], 32'h12345678);
        r1_req = 0; r1_we = 0;
        tick();

        // Reset while WAIT with memory stalled
        hang = 1; r0_we = 0; r0_addr = 14'h0020; r0_req = 1; base = rdcnt[0];
        tick();
        check("rw_gnt", gnt[0], 2'b01);
        tick();
        check("rw_busy", busy[0], 1);
        reset = 1;
        tick();
        check("rw_no_done", {done[0], mrd[0], gnt[0]}, 0);
        check("rw_rdata_clr", rd0[0], 32'h0);
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rw_sync%0d", i), {gnt[0], done[0], 3'd0, busy[0]}, 32'h1);
        end
        mem_data = 32'h55AA55AA; hang = 0;
        k = 0;
        while (gnt[0] != 2'b01 && k < 10) begin
            tick();
            k++;
        end
        check("rw_regnt_lat", k, 3);
        repeat (3) tick();
        check("rw_done",  done[0], 2'b01);
        check("rw_rdata", rd0[0], 32'h55AA55AA);
        r0_req = 0;
        check("rw_reads", rdcnt[0] - base, 2);
        tick();

        // Watchdog
        hang = 1; r0_addr = 14'h0030; r0_req = 1;
        tick();
        check("wd_gnt", gnt[0], 2'b01);
        k = 0;
        while (done[0] == 2'b00 && k < 40) begin
            tick();
            k++;
        end
        r0_req = 0;
        check("wd_lat",   k, 17);
        check("wd_done",  done[0], 2'b01);
        check("wd_rdata", rd0[0], 32'hDEADBEEF);
        check("wd_err",   err[0], 1);
        hang = 0;
        repeat (4) tick();
        check("wd_err_sticky", {err[0], busy[0]}, 2'b10);
        mem_data = 32'h00000077; r0_req = 1;
        repeat (4) tick();
        check("wd_after_done", done[0], 2'b01);
        check("wd_after_data", rd0[0], 32'h00000077);
        check("wd_err_still",  err[0], 1);
        r0_req = 0;
        reset = 1;
        tick();
        check("wd_err_clr", err[0], 0);
        reset = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1, "timeout");
    end

endmodule
